// File: rtl/mpx_hilo_unit.sv
// HI/LO architectural register pair with a result interlock for the divider
// and multiplier, plus MFHI/MFLO/MTHI/MTLO service for the issue stage.
module mpx_hilo_unit #(
   parameter int TIMEOUT_CYCLES = 40
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        div_start_i,
   input  logic        mul_start_i,
   input  logic        flush_i,
   input  logic        div_valid_i,
   input  logic [31:0] div_hi_i,
   input  logic [31:0] div_lo_i,
   input  logic        mul_valid_i,
   input  logic [31:0] mul_hi_i,
   input  logic [31:0] mul_lo_i,
   input  logic        op_valid_i,
   input  logic [1:0]  op_sel_i,
   input  logic [31:0] op_data_i,
   output logic        stall_o,
   output logic        result_valid_o,
   output logic [31:0] result_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        timeout_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [31:0]   result_q, result_d;
   logic          result_valid_q, result_valid_d;
   logic          timeout_q, timeout_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          start, wb, commit, accept;
   logic [31:0]   wb_hi, wb_lo, hi_src, lo_src;

   // A start coinciding with a flush belongs to a squashed instruction.
   assign start  = (div_start_i | mul_start_i) & ~flush_i;
   assign wb     = div_valid_i | mul_valid_i;
   assign wb_hi  = div_valid_i ? div_hi_i : mul_hi_i;
   assign wb_lo  = div_valid_i ? div_lo_i : mul_lo_i;
   assign commit = (state_q == ST_BUSY) & wb;
   assign accept = op_valid_i & ~flush_i & ((state_q == ST_IDLE) | commit);

   // Values seen by an op this cycle include a same-cycle writeback.
   assign hi_src = commit ? wb_hi : hi_q;
   assign lo_src = commit ? wb_lo : lo_q;

   assign stall_o = op_valid_i & (state_q != ST_IDLE) & ~commit & ~flush_i;

   always_comb begin
      state_d        = state_q;
      hi_d           = hi_src;
      lo_d           = lo_src;
      result_d       = result_q;
      result_valid_d = 1'b0;
      cnt_d          = cnt_q;
      timeout_d      = timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (start)        state_d = ST_BUSY;
            else if (wb)      state_d = ST_IDLE;
            else if (flush_i) state_d = ST_DISCARD;
         end
         ST_DISCARD: begin
            if (start)   state_d = ST_BUSY;
            else if (wb) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q != ST_IDLE) begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
         if (cnt_d == CNT_MAX) timeout_d = 1'b1;
      end
      if (state_d == ST_IDLE || start) cnt_d = '0;

      if (accept) begin
         case (op_sel_i)
            2'b00: begin result_d = lo_src; result_valid_d = 1'b1; end
            2'b01: begin result_d = hi_src; result_valid_d = 1'b1; end
            2'b10: lo_d = op_data_i;
            default: hi_d = op_data_i;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         hi_q           <= '0;
         lo_q           <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         cnt_q          <= '0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         hi_q           <= hi_d;
         lo_q           <= lo_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         cnt_q          <= cnt_d;
         timeout_q      <= timeout_d;
      end
   end

   assign hi_o           = hi_q;
   assign lo_o           = lo_q;
   assign result_o       = result_q;
   assign result_valid_o = result_valid_q;
   assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_mpx_hilo_unit.sv
// Directed bench for mpx_hilo_unit: divider/multiplier writebacks, interlock,
// bypass, flush discard and the sticky timeout.
module tb_mpx_hilo_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        div_start_i, mul_start_i, flush_i;
   logic        div_valid_i, mul_valid_i;
   logic [31:0] div_hi_i, div_lo_i, mul_hi_i, mul_lo_i;
   logic        op_valid_i;
   logic [1:0]  op_sel_i;
   logic [31:0] op_data_i;
   logic        stall_o, result_valid_o, timeout_o;
   logic [31:0] result_o, hi_o, lo_o;

   int n_checks = 0;
   int n_errors = 0;

   mpx_hilo_unit #(.TIMEOUT_CYCLES(40)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .div_start_i(div_start_i), .mul_start_i(mul_start_i), .flush_i(flush_i),
      .div_valid_i(div_valid_i), .div_hi_i(div_hi_i), .div_lo_i(div_lo_i),
      .mul_valid_i(mul_valid_i), .mul_hi_i(mul_hi_i), .mul_lo_i(mul_lo_i),
      .op_valid_i(op_valid_i), .op_sel_i(op_sel_i), .op_data_i(op_data_i),
      .stall_o(stall_o), .result_valid_o(result_valid_o), .result_o(result_o),
      .hi_o(hi_o), .lo_o(lo_o), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge; registered outputs are then stable for checking.
   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic idle_inputs();
      div_start_i = 0; mul_start_i = 0; flush_i = 0;
      div_valid_i = 0; mul_valid_i = 0;
      div_hi_i = 0; div_lo_i = 0; mul_hi_i = 0; mul_lo_i = 0;
      op_valid_i = 0; op_sel_i = 2'b00; op_data_i = 0;
   endtask

   logic stall_all_high;

   initial begin
      idle_inputs();
      rst_i = 1;
      ticks(2);
      rst_i = 0;
      check("rst_hi", hi_o, 32'h0);
      check("rst_lo", lo_o, 32'h0);
      check("rst_result", result_o, 32'h0);
      check("rst_result_valid", {31'b0, result_valid_o}, 32'h0);
      check("rst_timeout", {31'b0, timeout_o}, 32'h0);
      op_valid_i = 1; op_sel_i = 2'b00; #1;
      check("rst_idle_no_stall", {31'b0, stall_o}, 32'h0);
      op_valid_i = 0;

      // DIV 7 / -2 with MFLO waiting one cycle after start
      tick();
      div_start_i = 1;
      tick();
      div_start_i = 0;
      op_valid_i = 1; op_sel_i = 2'b00;
      stall_all_high = 1;
      for (int c = 1; c < 34; c++) begin
         #1;
         if (stall_o !== 1'b1) stall_all_high = 0;
         tick();
      end
      check("div_stall_held", {31'b0, stall_all_high}, 32'h1);
      div_valid_i = 1; div_hi_i = 32'h1; div_lo_i = 32'hFFFF_FFFD; #1;
      check("div_wb_stall_drop", {31'b0, stall_o}, 32'h0);
      tick();
      idle_inputs();
      check("div_hi", hi_o, 32'h1);
      check("div_lo", lo_o, 32'hFFFF_FFFD);
      check("mflo_bypass_valid", {31'b0, result_valid_o}, 32'h1);
      check("mflo_bypass_data", result_o, 32'hFFFF_FFFD);
      tick();
      check("result_valid_clears", {31'b0, result_valid_o}, 32'h0);
      check("result_holds", result_o, 32'hFFFF_FFFD);

      // MTHI then MFHI in IDLE
      op_valid_i = 1; op_sel_i = 2'b11; op_data_i = 32'hA5A5_A5A5; #1;
      check("mthi_no_stall", {31'b0, stall_o}, 32'h0);
      tick();
      check("mthi_hi", hi_o, 32'hA5A5_A5A5);
      check("mthi_no_result", {31'b0, result_valid_o}, 32'h0);
      op_sel_i = 2'b01; op_data_i = 32'h0;
      tick();
      op_valid_i = 0;
      check("mfhi_valid", {31'b0, result_valid_o}, 32'h1);
      check("mfhi_data", result_o, 32'hA5A5_A5A5);

      // DIV flushed at cycle 10; late writeback must be discarded
      div_start_i = 1;
      tick();
      div_start_i = 0;
      ticks(9);
      flush_i = 1; op_valid_i = 1; op_sel_i = 2'b00; #1;
      check("flush_no_stall", {31'b0, stall_o}, 32'h0);
      tick();
      flush_i = 0; #1;
      check("flush_op_cancelled", {31'b0, result_valid_o}, 32'h0);
      check("discard_stall", {31'b0, stall_o}, 32'h1);
      ticks(23);
      div_valid_i = 1; div_hi_i = 32'h3; div_lo_i = 32'h9; #1;
      check("discard_wb_stall", {31'b0, stall_o}, 32'h1);
      tick();
      div_valid_i = 0; #1;
      check("discard_hi", hi_o, 32'hA5A5_A5A5);
      check("discard_lo", lo_o, 32'hFFFF_FFFD);
      check("discard_idle_no_stall", {31'b0, stall_o}, 32'h0);
      tick();
      op_valid_i = 0;
      check("post_discard_mflo", result_o, 32'hFFFF_FFFD);

      // MTLO coincident with multiplier writeback
      mul_start_i = 1;
      tick();
      mul_start_i = 0;
      ticks(3);
      mul_valid_i = 1; mul_hi_i = 32'h5; mul_lo_i = 32'h6;
      op_valid_i = 1; op_sel_i = 2'b10; op_data_i = 32'h1234;
      tick();
      idle_inputs();
      check("mtlo_wb_hi", hi_o, 32'h5);
      check("mtlo_wb_lo", lo_o, 32'h1234);
      check("mtlo_wb_no_result", {31'b0, result_valid_o}, 32'h0);

      // MFHI bypass on multiplier writeback
      mul_start_i = 1;
      tick();
      mul_start_i = 0;
      mul_valid_i = 1; mul_hi_i = 32'h11; mul_lo_i = 32'h22;
      op_valid_i = 1; op_sel_i = 2'b01;
      tick();
      idle_inputs();
      check("mfhi_bypass", result_o, 32'h11);
      check("mul_lo", lo_o, 32'h22);

      // Writeback while IDLE is ignored; div wins a double strobe elsewhere
      div_valid_i = 1; div_hi_i = 32'hDEAD; div_lo_i = 32'hBEEF;
      tick();
      idle_inputs();
      check("idle_wb_ignored_hi", hi_o, 32'h11);
      div_start_i = 1;
      tick();
      div_start_i = 0;
      div_valid_i = 1; div_hi_i = 32'h77; div_lo_i = 32'h88;
      mul_valid_i = 1; mul_hi_i = 32'h99; mul_lo_i = 32'hAA;
      tick();
      idle_inputs();
      check("div_priority_hi", hi_o, 32'h77);
      check("div_priority_lo", lo_o, 32'h88);

      // Start killed by same-cycle flush stays IDLE
      div_start_i = 1; flush_i = 1;
      tick();
      idle_inputs();
      op_valid_i = 1; op_sel_i = 2'b00; #1;
      check("start_flush_idle", {31'b0, stall_o}, 32'h0);
      tick();
      op_valid_i = 0;
      check("start_flush_mflo", result_o, 32'h88);

      // Timeout after 40 BUSY cycles, sticky across a late writeback
      div_start_i = 1;
      tick();
      div_start_i = 0;
      ticks(39);
      check("timeout_not_yet", {31'b0, timeout_o}, 32'h0);
      tick();
      check("timeout_set", {31'b0, timeout_o}, 32'h1);
      div_valid_i = 1; div_hi_i = 32'h1; div_lo_i = 32'h2;
      tick();
      idle_inputs();
      check("timeout_sticky", {31'b0, timeout_o}, 32'h1);
      check("late_wb_hi", hi_o, 32'h1);
      ticks(3);
      check("timeout_sticky_idle", {31'b0, timeout_o}, 32'h1);

      // Reset mid-operation
      mul_start_i = 1;
      tick();
      mul_start_i = 0;
      rst_i = 1;
      tick();
      rst_i = 0;
      op_valid_i = 1; op_sel_i = 2'b01; #1;
      check("reset_timeout_clear", {31'b0, timeout_o}, 32'h0);
      check("reset_hi_clear", hi_o, 32'h0);
      check("reset_abandon_no_stall", {31'b0, stall_o}, 32'h0);
      tick();
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
